dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder on the memory side of the multicycle core's MEM stage. It accepts one load/store request at a time from the EX/MEM register, drives a synchronous single-port SRAM with a configurable number of wait states, and returns a one-cycle completion pulse. The core's stage controller stays in MEM until that pulse arrives, then commits PC and RF. Out-of-range addresses are flagged, never forwarded to the SRAM.

## Interface
- ADDR_W, 16, word address width
- DATA_W, 16, data word width
- MEM_WORDS, 4096, implemented SRAM words; addresses >= MEM_WORDS are out of range
- WAIT_CYC, 2, wait-state count, legal range 1..15 (SRAM read latency is 1)

- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  core MEM-stage request; held until accepted
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_ready  out  1  responder idle; accept on req_valid & req_ready
- rsp_valid  out  1  single-cycle completion pulse
- rsp_rdata  out  DATA_W  load data; held until the next completed load
- rsp_err  out  1  address out of range, valid with rsp_valid
- mem_en  out  1  SRAM strobe, one cycle per in-range access
- mem_we  out  1  SRAM write enable, qualified by mem_en
- mem_addr  out  ADDR_W  SRAM address (registered request address)
- mem_wdata  out  DATA_W  SRAM write data (registered)
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE:
  - req_ready=1.
  - On accept: register we/addr/wdata; compute err = (addr >= MEM_WORDS); load cnt=WAIT_CYC; go to WAIT.
- WAIT:
  - req_ready=0.
  - mem_en=1 only in the first WAIT cycle (cnt==WAIT_CYC) and only if !err.
  - cnt decrements every edge.
  - At the edge where cnt==0:
    - Load, !err: capture mem_rdata into rsp_rdata.
    - Load, err: rsp_rdata <= 0.
    - Store: rsp_rdata unchanged.
    - Go to RESP.
- RESP:
  - rsp_valid=1 and rsp_err=err for exactly this cycle; req_ready=0.
  - Next state is always IDLE.
- Errored accesses keep the same latency as good ones, so the core sees deterministic timing.
- req_valid while not in IDLE is ignored; the core holds the request. No queuing, no back-to-back accept from RESP.
- Stores write on the mem_en cycle. rsp_valid for a store means the write has been issued.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cnt=0.
- Reset asserted mid-access: immediate return to IDLE, all outputs at reset values, in-flight access dropped with no rsp_valid. A store whose mem_en cycle has already passed is not rolled back.

## Timing
- Accept edge E0. WAIT lasts WAIT_CYC+1 cycles. rsp_valid is high in the cycle between edges E(WAIT_CYC+1) and E(WAIT_CYC+2).
- Total request-to-response latency: WAIT_CYC+2 cycles.
- Next accept at the earliest: edge E(WAIT_CYC+3).
- mem_en is high in the cycle after E0. mem_rdata is sampled at edge E(WAIT_CYC+1), which is at least one cycle after the strobe for any legal WAIT_CYC.
- mem_addr, mem_wdata and mem_we are stable from E0 until the next accept.
- All outputs are registered or pure state decodes. No combinational path from req_* to any output.

## Structure
- Package dmem_pkg: state enum (IDLE/WAIT/RESP, 2-bit), default WAIT_CYC, counter width constant (4 bits).
- Sub-module wait_counter:
  - Loadable 4-bit down-counter with load, enable and zero outputs.
  - Used for cnt; reusable by the instruction-fetch responder.
- Elaboration check: 1 <= WAIT_CYC <= 15 and MEM_WORDS <= 2**ADDR_W.

## Test plan
- Reset release, WAIT_CYC=2, load from addr 0x0010 preset to 0xBEEF -> mem_en one cycle after accept; rsp_valid 4 cycles after accept with rsp_rdata=0xBEEF, rsp_err=0.
- Store 0x1234 to 0x0020, then load 0x0020 -> one mem_en with mem_we=1, later rsp_rdata=0x1234; rsp_rdata unchanged after the store's rsp_valid.
- Load addr 0x1000 (= MEM_WORDS) -> mem_en never asserted, rsp_err=1, rsp_rdata=0, same 4-cycle latency.
- req_valid held high continuously over two requests -> second accepted exactly at E5, req_ready=0 throughout WAIT and RESP.
- resetn pulsed low during the second WAIT cycle -> all outputs at reset values asynchronously, no rsp_valid, req_ready=1 after release.
- WAIT_CYC=1 build, load -> rsp_valid 3 cycles after accept with correct data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  // Counter width; bounds the legal wait-state range to 1..15.
  localparam int unsigned CntW = 4;

  localparam int unsigned WaitCycDef = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side request/response bus of the data-memory responder.
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // Core MEM stage side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter that parks at zero; shared by the memory responders.
module wait_counter
  import dmem_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  input  logic            en,
  output logic [CntW-1:0] cnt,
  output logic            zero
);

  // Load has priority; decrement stops at zero instead of wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CntW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait states, one-cycle completion pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned WAIT_CYC  = WaitCycDef
) (
  input  logic              clk,
  input  logic              resetn,
  dmem_responder_if.slave   bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if ((WAIT_CYC < 1) || (WAIT_CYC > 15) ||
      (64'(MEM_WORDS) > (64'd1 << ADDR_W))) begin : gen_param_check
    $error("dmem_responder: illegal WAIT_CYC or MEM_WORDS");
  end

  // Compare one bit wider so MEM_WORDS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] MemWordsW = (ADDR_W + 1)'(MEM_WORDS);
  localparam logic [CntW-1:0] WaitLoad  = CntW'(WAIT_CYC);

  state_e            state_q, state_d;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic [CntW-1:0]   cnt;
  logic              cnt_zero;

  assign accept = (state_q == StIdle) && bus.req_valid;

  wait_counter u_wait_counter (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .load_val (WaitLoad),
    .en       (state_q == StWait),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; errored accesses walk the same path for fixed latency.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = StWait;
      StWait:  if (cnt_zero) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture on accept; address/data/we stay stable until the next accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      mem_we    <= bus.req_we;
      mem_addr  <= bus.req_addr;
      mem_wdata <= bus.req_wdata;
      err_q     <= ({1'b0, bus.req_addr} >= MemWordsW);
    end
  end

  // Load data capture on the last WAIT edge; stores leave it untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if ((state_q == StWait) && cnt_zero && !mem_we) begin
      rdata_q <= err_q ? '0 : mem_rdata;
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_err   = (state_q == StResp) && err_q;
    bus.rsp_rdata = rdata_q;
    mem_en        = (state_q == StWait) && (cnt == WaitLoad) && !err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int W  = 2;
  localparam int NW = 4096;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  dmem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  dmem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  logic        mem_en, mem_we, mem1_en, mem1_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, mem1_addr, mem1_wdata, mem1_rdata;

  logic [15:0] sram  [NW];
  logic [15:0] sram1 [NW];

  dmem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(NW), .WAIT_CYC(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  dmem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(NW), .WAIT_CYC(1)) dut1 (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus1.slave),
    .mem_en    (mem1_en),
    .mem_we    (mem1_we),
    .mem_addr  (mem1_addr),
    .mem_wdata (mem1_wdata),
    .mem_rdata (mem1_rdata)
  );

  // Synchronous single-port SRAMs, read latency 1.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
    if (mem1_en) begin
      if (mem1_we) sram1[mem1_addr] <= mem1_wdata;
      else         mem1_rdata <= sram1[mem1_addr];
    end
  end

  // Reference model: word array plus last load result.
  logic [15:0] ref_mem [NW];
  logic [15:0] last_rdata = 16'h0;

  task automatic model_step(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            output logic [15:0] exp_rdata, output logic exp_err);
    exp_err = (int'(addr) >= NW);
    if (!we) last_rdata = exp_err ? 16'h0 : ref_mem[addr[11:0]];
    else if (!exp_err) ref_mem[addr[11:0]] = wdata;
    exp_rdata = last_rdata;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One complete transaction on the W=2 instance with full timing checks.
  task automatic do_req(input string name, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata,
                        input logic exp_err);
    int lat = 0, en_cnt = 0, en_at = 0;
    bit got = 0, ready_bad = 0, en_bad = 0;
    logic [15:0] rd = 16'h0;
    logic er = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    check({name, " ready_before_accept"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (mem_en) begin
        en_cnt++;
        en_at = k;
        if (mem_we !== we || mem_addr !== addr || (we && mem_wdata !== wdata)) en_bad = 1;
      end
      if (bus.req_ready) ready_bad = 1;
      if (bus.rsp_valid) begin
        got = 1;
        lat = k;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
      end
      if (!got) @(negedge clk);
    end
    check({name, " latency"}, 32'(lat), 32'(W + 2));
    check({name, " mem_en_count"}, 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
    if (!exp_err) check({name, " mem_en_cycle"}, 32'(en_at), 32'd1);
    check({name, " mem_bus_fields"}, 32'(en_bad), 32'd0);
    check({name, " ready_low_busy"}, 32'(ready_bad), 32'd0);
    check({name, " rsp_rdata"}, 32'(rd), 32'(exp_rdata));
    check({name, " rsp_err"}, 32'(er), 32'(exp_err));
    @(negedge clk);
    check({name, " pulse_one_cycle"}, 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
    check({name, " rdata_held"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
    check({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({name, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    check({name, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({name, " mem_ctl"}, 32'({mem_en, mem_we}), 32'd0);
    check({name, " mem_addr"}, 32'(mem_addr), 32'd0);
    check({name, " mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t vecs [9];
    logic [15:0] er_d, v;
    logic ee;
    int lat, first_ready, en_cnt;
    bit got, seen_rsp;

    bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    for (int i = 0; i < NW; i++) begin
      v = 16'($urandom);
      sram[i]    <= v;
      sram1[i]   <= v;
      ref_mem[i] = v;
    end
    sram[16'h0010]  <= 16'hBEEF; sram1[16'h0010] <= 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
    sram[16'h0FFF]  <= 16'hA5A5; ref_mem[16'h0FFF] = 16'hA5A5;

    #1;
    check_reset_outputs("in_reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_release");

    vecs[0] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b1, 16'h0020, 16'h1234, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0};
    vecs[3] = '{1'b0, 16'h1000, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h5555, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 16'h0FFF, 16'h0000, 16'hA5A5, 1'b0};
    vecs[6] = '{1'b1, 16'h0FFF, 16'h0F0F, 16'hA5A5, 1'b0};
    vecs[7] = '{1'b0, 16'h0FFF, 16'h0000, 16'h0F0F, 1'b0};
    vecs[8] = '{1'b1, 16'h1000, 16'h7777, 16'h0F0F, 1'b1};
    foreach (vecs[i]) begin
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err);
      model_step(vecs[i].we, vecs[i].addr, vecs[i].wdata, er_d, ee);
    end

    // req_valid held across two requests: second accept lands on E(W+3).
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0010;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.req_addr = 16'h0020;
    first_ready = 0; seen_rsp = 0;
    for (int k = 1; k <= 20 && first_ready == 0; k++) begin
      if (bus.req_ready) first_ready = k;
      else begin
        if (bus.rsp_valid) seen_rsp = 1;
        @(negedge clk);
      end
    end
    check("hold first_rsp_seen", 32'(seen_rsp), 32'd1);
    check("hold next_ready_cycle", 32'(first_ready), 32'(W + 3));
    model_step(1'b0, 16'h0010, 16'h0, er_d, ee);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("hold second_accepted", 32'({bus.req_ready, mem_en}), 32'b01);
    check("hold second_addr", 32'(mem_addr), 32'h0020);
    model_step(1'b0, 16'h0020, 16'h0, er_d, ee);
    got = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (bus.rsp_valid) got = 1;
      else @(negedge clk);
    end
    check("hold second_rdata", 32'(got ? bus.rsp_rdata : 16'hxxxx), 32'(er_d));

    // Reset during the second WAIT cycle drops the access.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0010;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    last_rdata = 16'h0;
    @(negedge clk);
    resetn = 1'b1;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rsp_valid || !bus.req_ready) got = 1;
    end
    check("mid_reset no_rsp_ready_high", 32'(got), 32'd0);

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      logic        rwe;
      logic [15:0] raddr, rwdata;
      rwe    = 1'($urandom_range(0, 1));
      rwdata = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       raddr = 16'($urandom_range(NW, 16'hFFFF));
        1, 2:    raddr = 16'($urandom_range(0, NW - 1));
        default: raddr = 16'($urandom_range(16'h0040, 16'h004F));
      endcase
      model_step(rwe, raddr, rwdata, er_d, ee);
      do_req($sformatf("rand%0d", t), rwe, raddr, rwdata, er_d, ee);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // WAIT_CYC=1 instance: response three cycles after accept.
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 16'h0010;
    check("w1 ready", 32'(bus1.req_ready), 32'd1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    lat = 0; en_cnt = 0; got = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (mem1_en) en_cnt++;
      if (bus1.rsp_valid) begin got = 1; lat = k; end
      else @(negedge clk);
    end
    check("w1 latency", 32'(lat), 32'd3);
    check("w1 mem_en_count", 32'(en_cnt), 32'd1);
    check("w1 rsp_rdata", 32'(bus1.rsp_rdata), 32'hBEEF);
    check("w1 rsp_err", 32'(bus1.rsp_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
